// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM driver slice.
// The optional gamma stage is enabled with `define LED_PWM_GAMMA_EN.
`ifndef LED_PWM_PKG_MACROS
`define LED_PWM_PKG_MACROS
`define LED_PWM_PERIOD_MAX(w) ((1 << (w)) - 2)
`define LED_PWM_FULL_ON(w) ((1 << (w)) - 1)
`define LED_PWM_SLICE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package led_pwm_pkg;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_if.sv
// Duty-load / PWM-output bundle between a duty source and led_pwm_driver.
interface led_pwm_if
  import led_pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1
);
  logic                        ena;
  logic [CHANNELS*WIDTH-1:0]   duty;
  logic                        duty_valid;
  logic [CHANNELS-1:0]         pwm_out;
  logic                        period_tick;
  logic                        update_done;

  modport master (
    output ena, duty, duty_valid,
    input  pwm_out, period_tick, update_done
  );

  modport slave (
    input  ena, duty, duty_valid,
    output pwm_out, period_tick, update_done
  );
endinterface

// File: rtl/led_pwm_prescaler.sv
// Divides clk by PRESCALE into a one-cycle PWM step strobe while ena is high.
module led_pwm_prescaler
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic step
);
  localparam int            CW   = cnt_w(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_q, pre_cnt_d;

  assign step = ena && (pre_cnt_q == LAST);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (ena) pre_cnt_d = step ? '0 : pre_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end
endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel period-aligned LED PWM with shadowed duty registers.
// Define LED_PWM_GAMMA_EN to store a squared (gamma-corrected) duty at commit.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  led_pwm_if.slave    bus
);
  localparam logic [WIDTH-1:0] PERIOD_MAX = WIDTH'(`LED_PWM_PERIOD_MAX(WIDTH));
`ifdef LED_PWM_GAMMA_EN
  localparam logic [WIDTH-1:0] FULL_ON    = WIDTH'(`LED_PWM_FULL_ON(WIDTH));
`endif

  // Mapping applied once per commit; the compare path never sees a multiplier.
  function automatic logic [WIDTH-1:0] gamma_map(input logic [WIDTH-1:0] a);
`ifdef LED_PWM_GAMMA_EN
    logic [2*WIDTH-1:0] prod;
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(a) + (2*WIDTH)'(FULL_ON);
    return prod[2*WIDTH-1:WIDTH];
`else
    return a;
`endif
  endfunction

  logic             step;
  logic             boundary;
  logic             commit;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic             pending_q, pending_d;
  logic             period_tick_q;
  logic             update_done_q;

  led_pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .step  (step)
  );

  assign boundary = step && (pcnt_q == PERIOD_MAX);
  // A load landing on the boundary itself is committed in the same boundary.
  assign commit   = boundary && (pending_q || bus.duty_valid);

  always_comb begin
    pcnt_d = pcnt_q;
    if (step) pcnt_d = boundary ? '0 : pcnt_q + 1'b1;
    pending_d = pending_q;
    if (boundary)            pending_d = 1'b0;
    else if (bus.duty_valid) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      pending_q     <= 1'b0;
      period_tick_q <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      pending_q     <= pending_d;
      period_tick_q <= boundary;
      update_done_q <= commit;
    end
  end

  assign bus.period_tick = period_tick_q;
  assign bus.update_done = update_done_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] src;
    logic             pwm_q;

    assign src = bus.duty_valid ? `LED_PWM_SLICE(bus.duty, i, WIDTH) : shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (bus.duty_valid) shadow_q <= `LED_PWM_SLICE(bus.duty, i, WIDTH);
        if (commit)         active_q <= gamma_map(src);
        if (bus.ena)        pwm_q    <= (pcnt_q < active_q);
      end
    end

    assign bus.pwm_out[i] = pwm_q;
  end
endmodule
